// File: rtl/pkt_fifo_writer.sv
// rtl/pkt_fifo_writer.sv - packet ingress writer with commit/rewind control of a sync FIFO
//
// Purpose: writes {eop, sop, data} beats into a fifo_sync built with pointer
// reset support, holds each packet uncommitted until the filter decides, and
// either advances commit_wptr (keep) or rewinds the FIFO write pointer to the
// packet start (drop, overflow, malformed).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready             beat handshake
//   in_data, in_sop, in_eop       beat payload and packet delimiters
//   dec_valid/dec_ready, dec_drop filter decision handshake, 1 = drop
//   fifo_wdata, fifo_wen          FIFO write port
//   fifo_full, fifo_wptr          FIFO status
//   fifo_wrst, fifo_rst_wptr      FIFO write-pointer rewind
//   commit_wptr                   end of the last committed packet
//   pkt_commit/drop/ovf           single-cycle event pulses
//   cnt_commit/drop/ovf           saturating event counters

module pkt_fifo_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_DATA     = 18,
  parameter int W_CNT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_DATA-1:0]     in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  dec_valid,
  input  logic                  dec_drop,
  output logic                  dec_ready,
  output logic [W_DATA+1:0]     fifo_wdata,
  output logic                  fifo_wen,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic [ADDR_WIDTH:0]   commit_wptr,
  output logic                  pkt_commit,
  output logic                  pkt_drop,
  output logic                  pkt_ovf,
  output logic [W_CNT-1:0]      cnt_commit,
  output logic [W_CNT-1:0]      cnt_drop,
  output logic [W_CNT-1:0]      cnt_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WAIT_DEC,
    S_DISCARD,
    S_REWIND
  } state_t;

  state_t                r_state;
  logic                  r_ovf_flag;
  logic [ADDR_WIDTH:0]   r_start_ptr;
  logic [ADDR_WIDTH:0]   r_commit_wptr;
  logic [ADDR_WIDTH:0]   r_fifo_rst_wptr;
  logic                  r_fifo_wrst;
  logic                  r_pkt_commit;
  logic                  r_pkt_drop;
  logic                  r_pkt_ovf;
  logic [W_CNT-1:0]      r_cnt_commit;
  logic [W_CNT-1:0]      r_cnt_drop;
  logic [W_CNT-1:0]      r_cnt_ovf;

  logic                  w_accept;
  logic                  w_malformed;
  logic                  w_dec_hs;
  logic                  w_go_rewind;

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + W_CNT'(1);
  endfunction

  // A sop inside an open packet stalls the beat; it is taken again from IDLE
  // once the broken packet has been rewound.
  assign w_malformed = (r_state == S_RECV) && in_valid && in_sop;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DISCARD: in_ready = 1'b1;
      S_RECV:            in_ready = !fifo_full && !w_malformed;
      default:           in_ready = 1'b0;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign fifo_wen   = w_accept && (((r_state == S_IDLE) && in_sop) || (r_state == S_RECV));
  assign fifo_wdata = {in_eop, in_sop, in_data};
  assign dec_ready  = (r_state == S_WAIT_DEC);
  assign w_dec_hs   = dec_valid && dec_ready;

  // An overflowed packet is erased whatever the filter says.
  assign w_go_rewind = w_malformed ||
                       ((r_state == S_WAIT_DEC) && w_dec_hs && (dec_drop || r_ovf_flag));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ovf_flag      <= 1'b0;
      r_start_ptr     <= '0;
      r_commit_wptr   <= '0;
      r_fifo_rst_wptr <= '0;
      r_fifo_wrst     <= 1'b0;
      r_pkt_commit    <= 1'b0;
      r_pkt_drop      <= 1'b0;
      r_pkt_ovf       <= 1'b0;
      r_cnt_commit    <= '0;
      r_cnt_drop      <= '0;
      r_cnt_ovf       <= '0;
    end else begin
      r_fifo_wrst  <= 1'b0;
      r_pkt_commit <= 1'b0;
      r_pkt_drop   <= 1'b0;
      r_pkt_ovf    <= 1'b0;

      if (w_go_rewind) begin
        // wrst and the event pulse are registered so they appear together in
        // the single REWIND cycle.
        r_state         <= S_REWIND;
        r_fifo_wrst     <= 1'b1;
        r_fifo_rst_wptr <= r_start_ptr;
        r_ovf_flag      <= 1'b0;
        if (r_ovf_flag) begin
          r_pkt_ovf <= 1'b1;
          r_cnt_ovf <= sat_inc(r_cnt_ovf);
        end else begin
          r_pkt_drop <= 1'b1;
          r_cnt_drop <= sat_inc(r_cnt_drop);
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && in_sop) begin
              r_start_ptr <= fifo_wptr;
              // A sop arriving at a full FIFO cannot be stored; treat the
              // whole packet as overflowed.
              r_ovf_flag  <= fifo_full;
              if (in_eop)         r_state <= S_WAIT_DEC;
              else if (fifo_full) r_state <= S_DISCARD;
              else                r_state <= S_RECV;
            end
          end
          S_RECV: begin
            if (in_valid && fifo_full) begin
              r_ovf_flag <= 1'b1;
              r_state    <= S_DISCARD;
            end else if (w_accept && in_eop) begin
              r_state <= S_WAIT_DEC;
            end
          end
          S_DISCARD: begin
            if (w_accept && in_eop) r_state <= S_WAIT_DEC;
          end
          S_WAIT_DEC: begin
            // fifo_wptr already includes the eop word here.
            if (w_dec_hs) begin
              r_commit_wptr <= fifo_wptr;
              r_pkt_commit  <= 1'b1;
              r_cnt_commit  <= sat_inc(r_cnt_commit);
              r_state       <= S_IDLE;
            end
          end
          S_REWIND: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign fifo_wrst     = r_fifo_wrst;
  assign fifo_rst_wptr = r_fifo_rst_wptr;
  assign commit_wptr   = r_commit_wptr;
  assign pkt_commit    = r_pkt_commit;
  assign pkt_drop      = r_pkt_drop;
  assign pkt_ovf       = r_pkt_ovf;
  assign cnt_commit    = r_cnt_commit;
  assign cnt_drop      = r_cnt_drop;
  assign cnt_ovf       = r_cnt_ovf;

endmodule

// File: tb/tb_pkt_fifo_writer.sv
// tb/tb_pkt_fifo_writer.sv - directed self-checking bench for pkt_fifo_writer

module tb_pkt_fifo_writer;

  localparam int AW = 4;
  localparam int WD = 18;
  localparam int WC = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WD-1:0]   in_data;
  logic            in_sop;
  logic            in_eop;
  logic            dec_valid;
  logic            dec_drop;
  logic            dec_ready;
  logic [WD+1:0]   fifo_wdata;
  logic            fifo_wen;
  logic            fifo_full;
  logic [AW:0]     fifo_wptr;
  logic            fifo_wrst;
  logic [AW:0]     fifo_rst_wptr;
  logic [AW:0]     commit_wptr;
  logic            pkt_commit;
  logic            pkt_drop;
  logic            pkt_ovf;
  logic [WC-1:0]   cnt_commit;
  logic [WC-1:0]   cnt_drop;
  logic [WC-1:0]   cnt_ovf;

  int tests = 0;
  int fails = 0;

  // FIFO pointer model: 16 entries, no reads; ld presets both pointers.
  logic [AW:0] m_wptr;
  logic [AW:0] m_rptr;
  logic [AW:0] m_fill;
  logic        ld;
  logic [AW:0] ld_val;

  always @(posedge clk) begin
    if (reset) begin
      m_wptr <= '0;
      m_rptr <= '0;
    end else if (ld) begin
      m_wptr <= ld_val;
      m_rptr <= ld_val;
    end else if (fifo_wrst) begin
      m_wptr <= fifo_rst_wptr;
    end else if (fifo_wen && !fifo_full) begin
      m_wptr <= m_wptr + 5'd1;
    end
  end

  assign m_fill    = m_wptr - m_rptr;
  assign fifo_full = (m_fill == 5'd16);
  assign fifo_wptr = m_wptr;

  always #5 clk = ~clk;

  pkt_fifo_writer #(.ADDR_WIDTH(AW), .W_DATA(WD), .W_CNT(WC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .dec_valid(dec_valid), .dec_drop(dec_drop), .dec_ready(dec_ready),
    .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_full(fifo_full),
    .fifo_wptr(fifo_wptr), .fifo_wrst(fifo_wrst), .fifo_rst_wptr(fifo_rst_wptr),
    .commit_wptr(commit_wptr),
    .pkt_commit(pkt_commit), .pkt_drop(pkt_drop), .pkt_ovf(pkt_ovf),
    .cnt_commit(cnt_commit), .cnt_drop(cnt_drop), .cnt_ovf(cnt_ovf)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    dec_valid = 1'b0; dec_drop = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    tests++; if (dec_ready !== 1'b0) begin fails++; $display("FAIL rst_dec_ready got=%0h exp=0", dec_ready); end
    tests++; if ({fifo_wen, fifo_wrst} !== 2'b00) begin fails++; $display("FAIL rst_wen_wrst got=%0h exp=0", {fifo_wen, fifo_wrst}); end
    tests++; if ({commit_wptr, fifo_rst_wptr} !== 10'h0) begin fails++; $display("FAIL rst_ptrs got=%0h exp=0", {commit_wptr, fifo_rst_wptr}); end
    tests++; if ({pkt_commit, pkt_drop, pkt_ovf} !== 3'b000) begin fails++; $display("FAIL rst_pulses got=%0h exp=0", {pkt_commit, pkt_drop, pkt_ovf}); end
    tests++; if ({cnt_commit, cnt_drop, cnt_ovf} !== 48'h0) begin fails++; $display("FAIL rst_counters got=%0h exp=0", {cnt_commit, cnt_drop, cnt_ovf}); end
    cyc;
  endtask

  task automatic test_keep;
    logic [WD+1:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 3); in_data = WD'(18'h00100 + i);
      #1;
      tests++; if ({in_ready, fifo_wen} !== 2'b11) begin fails++; $display("FAIL keep_write beat=%0d got=%0h exp=3", i, {in_ready, fifo_wen}); end
      if (i == 0) begin
        exp_w = {1'b0, 1'b1, 18'h00100};
        tests++; if (fifo_wdata !== exp_w) begin fails++; $display("FAIL keep_wdata_sop got=%0h exp=%0h", fifo_wdata, exp_w); end
      end
      if (i == 3) begin
        exp_w = {1'b1, 1'b0, 18'h00103};
        tests++; if (fifo_wdata !== exp_w) begin fails++; $display("FAIL keep_wdata_eop got=%0h exp=%0h", fifo_wdata, exp_w); end
      end
      cyc;
    end
    idle_inputs();
    #1;
    tests++; if ({dec_ready, in_ready} !== 2'b10) begin fails++; $display("FAIL keep_wait_dec got=%0h exp=2", {dec_ready, in_ready}); end
    repeat (3) cyc;
    dec_valid = 1'b1; dec_drop = 1'b0;
    #1;
    tests++; if (commit_wptr !== 5'd0) begin fails++; $display("FAIL keep_commit_before got=%0d exp=0", commit_wptr); end
    cyc;
    dec_valid = 1'b0;
    #1;
    tests++; if (commit_wptr !== 5'd4) begin fails++; $display("FAIL keep_commit_wptr got=%0d exp=4", commit_wptr); end
    tests++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL keep_pkt_commit got=%0h exp=1", pkt_commit); end
    tests++; if (cnt_commit !== 16'd1) begin fails++; $display("FAIL keep_cnt_commit got=%0d exp=1", cnt_commit); end
    cyc;
    tests++; if ({pkt_commit, dec_ready} !== 2'b00) begin fails++; $display("FAIL keep_after got=%0h exp=0", {pkt_commit, dec_ready}); end
  endtask

  task automatic test_drop;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 2); in_data = WD'(18'h00200 + i);
      #1;
      tests++; if (fifo_wen !== 1'b1) begin fails++; $display("FAIL drop_write beat=%0d got=%0h exp=1", i, fifo_wen); end
      cyc;
    end
    idle_inputs();
    dec_valid = 1'b1; dec_drop = 1'b1;
    #1;
    tests++; if ({dec_ready, fifo_wptr} !== {1'b1, 5'd7}) begin fails++; $display("FAIL drop_wait got=%0h exp=%0h", {dec_ready, fifo_wptr}, {1'b1, 5'd7}); end
    cyc;
    dec_valid = 1'b0; dec_drop = 1'b0;
    #1;
    tests++; if ({fifo_wrst, fifo_rst_wptr} !== {1'b1, 5'd4}) begin fails++; $display("FAIL drop_rewind got=%0h exp=%0h", {fifo_wrst, fifo_rst_wptr}, {1'b1, 5'd4}); end
    tests++; if ({pkt_drop, pkt_commit, in_ready} !== 3'b100) begin fails++; $display("FAIL drop_pulse got=%0h exp=4", {pkt_drop, pkt_commit, in_ready}); end
    tests++; if (cnt_drop !== 16'd1) begin fails++; $display("FAIL drop_cnt got=%0d exp=1", cnt_drop); end
    tests++; if (commit_wptr !== 5'd4) begin fails++; $display("FAIL drop_commit_hold got=%0d exp=4", commit_wptr); end
    cyc;
    tests++; if ({fifo_wrst, pkt_drop, in_ready} !== 3'b001) begin fails++; $display("FAIL drop_after got=%0h exp=1", {fifo_wrst, pkt_drop, in_ready}); end
    tests++; if (fifo_wptr !== 5'd4) begin fails++; $display("FAIL drop_fifo_ptr got=%0d exp=4", fifo_wptr); end
  endtask

  task automatic test_overflow;
    ld = 1'b1; ld_val = 5'd0;
    cyc;
    ld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 19); in_data = WD'(i);
      #1;
      if (i == 16) begin
        tests++; if ({in_ready, fifo_full} !== 2'b01) begin fails++; $display("FAIL ovf_stall got=%0h exp=1", {in_ready, fifo_full}); end
        cyc;
        #1;
      end
      if (i < 16) begin
        tests++; if ({in_ready, fifo_wen} !== 2'b11) begin fails++; $display("FAIL ovf_write beat=%0d got=%0h exp=3", i, {in_ready, fifo_wen}); end
      end else begin
        tests++; if ({in_ready, fifo_wen} !== 2'b10) begin fails++; $display("FAIL ovf_sink beat=%0d got=%0h exp=2", i, {in_ready, fifo_wen}); end
      end
      cyc;
    end
    idle_inputs();
    dec_valid = 1'b1; dec_drop = 1'b0;
    #1;
    tests++; if (dec_ready !== 1'b1) begin fails++; $display("FAIL ovf_dec_ready got=%0h exp=1", dec_ready); end
    cyc;
    dec_valid = 1'b0;
    #1;
    tests++; if ({fifo_wrst, fifo_rst_wptr} !== {1'b1, 5'd0}) begin fails++; $display("FAIL ovf_rewind got=%0h exp=%0h", {fifo_wrst, fifo_rst_wptr}, {1'b1, 5'd0}); end
    tests++; if ({pkt_ovf, pkt_drop, pkt_commit} !== 3'b100) begin fails++; $display("FAIL ovf_pulse got=%0h exp=4", {pkt_ovf, pkt_drop, pkt_commit}); end
    tests++; if ({cnt_ovf, cnt_commit} !== {16'd1, 16'd1}) begin fails++; $display("FAIL ovf_counts got=%0h exp=%0h", {cnt_ovf, cnt_commit}, {16'd1, 16'd1}); end
    tests++; if (commit_wptr !== 5'd4) begin fails++; $display("FAIL ovf_commit_hold got=%0d exp=4", commit_wptr); end
    cyc;
    tests++; if ({fifo_wptr, fifo_full} !== 6'h00) begin fails++; $display("FAIL ovf_fifo_after got=%0h exp=0", {fifo_wptr, fifo_full}); end
  endtask

  task automatic test_wrap;
    ld = 1'b1; ld_val = 5'd30;
    cyc;
    ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == 4); in_data = WD'(18'h00300 + i);
      #1;
      tests++; if (fifo_wen !== 1'b1) begin fails++; $display("FAIL wrap_write beat=%0d got=%0h exp=1", i, fifo_wen); end
      cyc;
    end
    idle_inputs();
    dec_valid = 1'b1; dec_drop = 1'b0;
    #1;
    cyc;
    dec_valid = 1'b0;
    #1;
    tests++; if (commit_wptr !== 5'd3) begin fails++; $display("FAIL wrap_commit_wptr got=%0d exp=3", commit_wptr); end
    tests++; if ({pkt_commit, cnt_commit} !== {1'b1, 16'd2}) begin fails++; $display("FAIL wrap_commit_evt got=%0h exp=%0h", {pkt_commit, cnt_commit}, {1'b1, 16'd2}); end
    cyc;
  endtask

  task automatic test_malformed;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0; in_data = WD'(18'h00400 + i);
      #1;
      tests++; if (fifo_wen !== 1'b1) begin fails++; $display("FAIL mal_write beat=%0d got=%0h exp=1", i, fifo_wen); end
      cyc;
    end
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = WD'(18'h00500);
    #1;
    tests++; if ({in_ready, fifo_wen} !== 2'b00) begin fails++; $display("FAIL mal_stall got=%0h exp=0", {in_ready, fifo_wen}); end
    cyc;
    tests++; if ({fifo_wrst, fifo_rst_wptr} !== {1'b1, 5'd3}) begin fails++; $display("FAIL mal_rewind got=%0h exp=%0h", {fifo_wrst, fifo_rst_wptr}, {1'b1, 5'd3}); end
    tests++; if ({pkt_drop, cnt_drop, in_ready} !== {1'b1, 16'd2, 1'b0}) begin fails++; $display("FAIL mal_drop got=%0h exp=%0h", {pkt_drop, cnt_drop, in_ready}, {1'b1, 16'd2, 1'b0}); end
    cyc;
    tests++; if ({in_ready, fifo_wen, fifo_wptr} !== {2'b11, 5'd3}) begin fails++; $display("FAIL mal_new_sop got=%0h exp=%0h", {in_ready, fifo_wen, fifo_wptr}, {2'b11, 5'd3}); end
    cyc;
    idle_inputs();
    dec_valid = 1'b1;
    #1;
    cyc;
    dec_valid = 1'b0;
    #1;
    tests++; if ({commit_wptr, cnt_commit} !== {5'd4, 16'd3}) begin fails++; $display("FAIL mal_commit got=%0h exp=%0h", {commit_wptr, cnt_commit}, {5'd4, 16'd3}); end
    cyc;
  endtask

  task automatic test_nonsop_reset;
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = WD'(18'h00600);
    #1;
    tests++; if ({in_ready, fifo_wen} !== 2'b10) begin fails++; $display("FAIL nonsop_sink got=%0h exp=2", {in_ready, fifo_wen}); end
    cyc;
    tests++; if ({fifo_wptr, pkt_drop, pkt_commit} !== {5'd4, 2'b00}) begin fails++; $display("FAIL nonsop_noevt got=%0h exp=%0h", {fifo_wptr, pkt_drop, pkt_commit}, {5'd4, 2'b00}); end
    in_sop = 1'b1;
    #1;
    cyc;
    in_sop = 1'b0;
    #1;
    tests++; if (fifo_wen !== 1'b1) begin fails++; $display("FAIL nonsop_recv_write got=%0h exp=1", fifo_wen); end
    cyc;
    idle_inputs();
    reset = 1'b1;
    cyc;
    tests++; if ({fifo_wrst, fifo_wen, in_ready, dec_ready} !== 4'b0010) begin fails++; $display("FAIL reset_ctrl got=%0h exp=2", {fifo_wrst, fifo_wen, in_ready, dec_ready}); end
    tests++; if ({commit_wptr, fifo_rst_wptr} !== 10'h0) begin fails++; $display("FAIL reset_ptrs got=%0h exp=0", {commit_wptr, fifo_rst_wptr}); end
    tests++; if ({cnt_commit, cnt_drop, cnt_ovf, pkt_commit, pkt_drop, pkt_ovf} !== 51'h0) begin fails++; $display("FAIL reset_stats got=%0h exp=0", {cnt_commit, cnt_drop, cnt_ovf, pkt_commit, pkt_drop, pkt_ovf}); end
    reset = 1'b0;
    in_valid = 1'b1; in_sop = 1'b0;
    #1;
    tests++; if ({fifo_wrst, fifo_wen, in_ready} !== 3'b001) begin fails++; $display("FAIL reset_idle got=%0h exp=1", {fifo_wrst, fifo_wen, in_ready}); end
    cyc;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    ld = 1'b0;
    ld_val = '0;
    reset = 1'b1;
    repeat (2) cyc;
    reset = 1'b0;
    test_reset();
    test_keep();
    test_drop();
    test_overflow();
    test_wrap();
    test_malformed();
    test_nonsop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
